// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: byte-wide instruction fetch sequencer.
// Walks the memory address through the four bytes of each 32-bit word,
// assembles them little-endian and hands the word to decode with a
// valid/ready handshake. Branch redirects drop any in-flight word and
// restart fetch at the aligned target.
//
// Optional build macro: FETCH_LANE_CHECK_EN
//   defined   -> sticky lane_err when memory-reported lane != byte being captured
//   undefined -> lane_err tied 0, mem_lane ignored
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no word in flight; mem_addr parked on fetch_pc
// ST_FETCH | capturing byte byte_cnt of the word at fetch_pc
// ST_VALID | assembled word presented to decode, waiting for instr_ready
module instr_fetch_seq #(
  parameter int unsigned           ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  input  logic [1:0]        mem_lane,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              busy,
  output logic              lane_err
);

  // Word alignment mask and word stride, sized to the address width.
  localparam logic [ADDR_W-1:0] ALIGN_MASK       = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [ADDR_W-1:0] WORD_STEP        = {{(ADDR_W-3){1'b0}}, 3'b100};
  localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } state_e;

  state_e            state_q,    state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       instr_q,    instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              valid_q,    valid_d;

  // High on an edge that stores a memory byte into the word being assembled.
  logic              capture;
  logic              xfer;

  assign xfer = valid_q && instr_ready;

  // Next-state and datapath: redirect overrides everything, else per-state work.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    byte_cnt_d = byte_cnt_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    capture    = 1'b0;

    if (redirect) begin
      // A word accepted in this same cycle already belongs to decode; only
      // the follow-on fetch address changes.
      fetch_pc_d = redirect_pc & ALIGN_MASK;
      byte_cnt_d = 2'd0;
      valid_d    = 1'b0;
      state_d    = fetch_en ? ST_FETCH : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fetch_en) begin
            state_d = ST_FETCH;
          end
        end

        ST_FETCH: begin
          // fetch_en is not sampled here: a started word always completes.
          capture                                = 1'b1;
          instr_d[{byte_cnt_q, 3'b000} +: 8]     = mem_data;
          byte_cnt_d                             = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            instr_pc_d = fetch_pc_q;
            valid_d    = 1'b1;
            state_d    = ST_VALID;
          end
        end

        ST_VALID: begin
          if (xfer) begin
            fetch_pc_d = fetch_pc_q + WORD_STEP;
            valid_d    = 1'b0;
            state_d    = fetch_en ? ST_FETCH : ST_IDLE;
          end
        end

        default: begin
          byte_cnt_d = 2'd0;
          valid_d    = 1'b0;
          state_d    = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC_ALIGNED;
      byte_cnt_q <= 2'd0;
      instr_q    <= 32'd0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      byte_cnt_q <= byte_cnt_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  assign mem_addr    = fetch_pc_q + {{(ADDR_W-2){1'b0}}, byte_cnt_q};
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign busy        = (state_q != ST_IDLE);

`ifdef FETCH_LANE_CHECK_EN
  logic lane_err_q, lane_err_d;

  // Any capture whose reported lane disagrees with the byte slot sets the flag.
  always_comb begin
    lane_err_d = lane_err_q;
    if (capture && (mem_lane != byte_cnt_q)) begin
      lane_err_d = 1'b1;
    end
  end

  // Sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_err_q <= 1'b0;
    end else begin
      lane_err_q <= lane_err_d;
    end
  end

  assign lane_err = lane_err_q;
`else
  logic unused_lane;
  assign unused_lane = (^mem_lane) ^ capture;
  assign lane_err    = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Testbench for instr_fetch_seq: directed vector table, a wrap/enable
// sequence on a second instance reset to 0xFC, a randomized run against a
// transaction-level model, and a lane-check sequence.
module tb_instr_fetch_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (RESET_PC = 0)
  logic        rst;
  logic        fetch_en, instr_ready, redirect;
  logic [7:0]  redirect_pc, mem_addr, mem_data, instr_pc;
  logic [1:0]  mem_lane;
  logic [31:0] instr;
  logic        instr_valid, busy, lane_err;

  // Wrap instance (RESET_PC = 0xFC)
  logic        b_rst;
  logic        b_fetch_en, b_instr_ready, b_redirect;
  logic [7:0]  b_redirect_pc, b_mem_addr, b_mem_data, b_instr_pc;
  logic [1:0]  b_mem_lane;
  logic [31:0] b_instr;
  logic        b_instr_valid, b_busy, b_lane_err;

  logic [7:0]  mem [256];
  logic        lane_force;
  logic [1:0]  lane_force_val;

  assign mem_data   = mem[mem_addr];
  assign mem_lane   = lane_force ? lane_force_val : mem_addr[1:0];
  assign b_mem_data = mem[b_mem_addr];
  assign b_mem_lane = b_mem_addr[1:0];

  instr_fetch_seq #(.ADDR_W(8), .RESET_PC(8'h00)) u_dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_lane(mem_lane), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .busy(busy), .lane_err(lane_err)
  );

  instr_fetch_seq #(.ADDR_W(8), .RESET_PC(8'hFC)) u_dut_wrap (
    .clk(clk), .rst(b_rst), .fetch_en(b_fetch_en), .mem_addr(b_mem_addr),
    .mem_data(b_mem_data), .mem_lane(b_mem_lane), .instr(b_instr), .instr_pc(b_instr_pc),
    .instr_valid(b_instr_valid), .instr_ready(b_instr_ready), .redirect(b_redirect),
    .redirect_pc(b_redirect_pc), .busy(b_busy), .lane_err(b_lane_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_word(input logic [7:0] a, input logic [31:0] w);
    mem[a]        = w[7:0];
    mem[a + 8'd1] = w[15:8];
    mem[a + 8'd2] = w[23:16];
    mem[a + 8'd3] = w[31:24];
  endtask

  function automatic logic [31:0] word_at(input logic [7:0] a);
    logic [7:0] a1, a2, a3;
    a1 = a + 8'd1;
    a2 = a + 8'd2;
    a3 = a + 8'd3;
    return {mem[a3], mem[a2], mem[a1], mem[a]};
  endfunction

  typedef struct {
    logic        fe, rdy, rd;
    logic [7:0]  rpc;
    logic [7:0]  addr;
    logic        v;
    logic [31:0] ins;
    logic [7:0]  pc;
    logic        bsy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic fe, input logic rdy, input logic rd, input logic [7:0] rpc,
                     input logic [7:0] addr, input logic v, input logic [31:0] ins,
                     input logic [7:0] pc, input logic bsy);
    vec_t r;
    r.fe = fe; r.rdy = rdy; r.rd = rd; r.rpc = rpc; r.addr = addr;
    r.v = v; r.ins = ins; r.pc = pc; r.bsy = bsy;
    vecs.push_back(r);
  endtask

  task automatic add_fetch4(input logic [7:0] base);
    for (int i = 0; i < 4; i++) add(1, 1, 0, 8'h00, base + 8'(i), 0, 32'h0, 8'h00, 1);
  endtask

  // Holds main reset for two cycles and releases it on a falling edge.
  task automatic reset_main();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0]  exp_pc;
    logic        hold_pending;
    logic [31:0] prev_ins;
    logic [7:0]  prev_pc;
    int          n_xfer;
    logic        fe_r, rdy_r, rd_r;
    logic [7:0]  rpc_r;
    logic        exp_lane;

    rst = 1'b1; b_rst = 1'b1;
    fetch_en = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = 8'h00;
    b_fetch_en = 1'b0; b_instr_ready = 1'b0; b_redirect = 1'b0; b_redirect_pc = 8'h00;
    lane_force = 1'b0; lane_force_val = 2'd0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    set_word(8'h04, 32'hE3A04005);
    set_word(8'h08, 32'hE3A01000);
    set_word(8'h0C, 32'hE2812001);
    set_word(8'h10, 32'hE2833004);
    set_word(8'h24, 32'hEA000010);
    set_word(8'h28, 32'hE3540002);
    set_word(8'hFC, 32'h12345678);

    // Directed timeline: word assembly, backpressure, mid-word redirect,
    // redirect coincident with transfer.
    add(1, 1, 0, 8'h00, 8'h00, 0, 32'h0, 8'h00, 0);
    add_fetch4(8'h00);
    add(1, 1, 0, 8'h00, 8'h00, 1, 32'h00000000, 8'h00, 1);
    add_fetch4(8'h04);
    add(1, 1, 0, 8'h00, 8'h04, 1, 32'hE3A04005, 8'h04, 1);
    add_fetch4(8'h08);
    for (int i = 0; i < 7; i++) add(1, 0, 0, 8'h00, 8'h08, 1, 32'hE3A01000, 8'h08, 1);
    add(1, 1, 0, 8'h00, 8'h08, 1, 32'hE3A01000, 8'h08, 1);
    add_fetch4(8'h0C);
    add(1, 1, 0, 8'h00, 8'h0C, 1, 32'hE2812001, 8'h0C, 1);
    add(1, 1, 0, 8'h00, 8'h10, 0, 32'h0, 8'h00, 1);
    add(1, 1, 0, 8'h00, 8'h11, 0, 32'h0, 8'h00, 1);
    add(1, 1, 1, 8'h29, 8'h12, 0, 32'h0, 8'h00, 1);
    add_fetch4(8'h28);
    add(1, 1, 0, 8'h00, 8'h28, 1, 32'hE3540002, 8'h28, 1);
    add(1, 1, 1, 8'h24, 8'h2C, 0, 32'h0, 8'h00, 1);
    add_fetch4(8'h24);
    add(1, 1, 1, 8'h10, 8'h24, 1, 32'hEA000010, 8'h24, 1);
    add_fetch4(8'h10);
    add(1, 1, 0, 8'h00, 8'h10, 1, 32'hE2833004, 8'h10, 1);

    reset_main();
    chk("reset instr", instr, 32'h0);
    chk("reset instr_pc", {24'h0, instr_pc}, 32'h0);
    chk("reset lane_err", {31'h0, lane_err}, 32'h0);
    for (int i = 0; i < vecs.size(); i++) begin
      chk($sformatf("vec%0d mem_addr", i), {24'h0, mem_addr}, {24'h0, vecs[i].addr});
      chk($sformatf("vec%0d valid", i), {31'h0, instr_valid}, {31'h0, vecs[i].v});
      chk($sformatf("vec%0d busy", i), {31'h0, busy}, {31'h0, vecs[i].bsy});
      if (vecs[i].v) begin
        chk($sformatf("vec%0d instr", i), instr, vecs[i].ins);
        chk($sformatf("vec%0d instr_pc", i), {24'h0, instr_pc}, {24'h0, vecs[i].pc});
      end
      fetch_en    = vecs[i].fe;
      instr_ready = vecs[i].rdy;
      redirect    = vecs[i].rd;
      redirect_pc = vecs[i].rpc;
      @(negedge clk);
    end
    redirect = 1'b0;

    // Wrap and enable on the instance reset to 0xFC.
    b_rst = 1'b0;
    chk("wrap reset mem_addr", {24'h0, b_mem_addr}, 32'hFC);
    chk("wrap reset busy", {31'h0, b_busy}, 32'h0);
    b_fetch_en = 1'b1;
    @(negedge clk);
    chk("wrap byte0 mem_addr", {24'h0, b_mem_addr}, 32'hFC);
    @(negedge clk);
    chk("wrap byte1 mem_addr", {24'h0, b_mem_addr}, 32'hFD);
    b_fetch_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("wrap byte3 mem_addr", {24'h0, b_mem_addr}, 32'hFF);
    @(negedge clk);
    chk("wrap valid", {31'h0, b_instr_valid}, 32'h1);
    chk("wrap instr", b_instr, 32'h12345678);
    chk("wrap instr_pc", {24'h0, b_instr_pc}, 32'hFC);
    b_instr_ready = 1'b1;
    @(negedge clk);
    chk("wrap idle busy", {31'h0, b_busy}, 32'h0);
    chk("wrap idle mem_addr", {24'h0, b_mem_addr}, 32'h00);
    chk("wrap idle valid", {31'h0, b_instr_valid}, 32'h0);
    @(negedge clk);
    chk("wrap still idle", {31'h0, b_busy}, 32'h0);
    b_fetch_en = 1'b1;
    @(negedge clk);
    chk("wrap refetch busy", {31'h0, b_busy}, 32'h1);
    chk("wrap refetch addr0", {24'h0, b_mem_addr}, 32'h00);
    @(negedge clk);
    chk("wrap refetch addr1", {24'h0, b_mem_addr}, 32'h01);
    b_fetch_en = 1'b0;

    // Randomized run against a transaction-level model: each accepted word
    // must be the next sequential word, or the word at the latest redirect.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    fetch_en = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
    reset_main();
    exp_pc = 8'h00;
    hold_pending = 1'b0;
    prev_ins = 32'h0;
    prev_pc = 8'h00;
    n_xfer = 0;
    for (int c = 0; c < 2000; c++) begin
      if (hold_pending) begin
        chk("rand hold valid", {31'h0, instr_valid}, 32'h1);
        chk("rand hold instr", instr, prev_ins);
        chk("rand hold instr_pc", {24'h0, instr_pc}, {24'h0, prev_pc});
      end
      if (instr_valid) chk("rand busy while valid", {31'h0, busy}, 32'h1);
      fe_r  = ($urandom_range(0, 9) != 0);
      rdy_r = ($urandom_range(0, 9) < 7);
      rd_r  = ($urandom_range(0, 31) == 0);
      rpc_r = 8'($urandom);
      fetch_en = fe_r; instr_ready = rdy_r; redirect = rd_r; redirect_pc = rpc_r;
      if (instr_valid && rdy_r) begin
        chk("rand xfer instr_pc", {24'h0, instr_pc}, {24'h0, exp_pc});
        chk("rand xfer instr", instr, word_at(exp_pc));
        exp_pc = exp_pc + 8'd4;
        n_xfer++;
      end
      if (rd_r) exp_pc = rpc_r & 8'hFC;
      hold_pending = instr_valid && !rdy_r && !rd_r;
      prev_ins = instr;
      prev_pc  = instr_pc;
      @(negedge clk);
    end
    chk("rand transfer count above 50", {31'h0, (n_xfer > 50)}, 32'h1);

    // Lane check: wrong lane reported on the byte-2 capture.
`ifdef FETCH_LANE_CHECK_EN
    exp_lane = 1'b1;
`else
    exp_lane = 1'b0;
`endif
    fetch_en = 1'b1; instr_ready = 1'b1; redirect = 1'b0;
    reset_main();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("lane byte2 mem_addr", {24'h0, mem_addr}, 32'h02);
    chk("lane before bad capture", {31'h0, lane_err}, 32'h0);
    lane_force = 1'b1; lane_force_val = 2'd0;
    @(negedge clk);
    lane_force = 1'b0;
    chk("lane after bad capture", {31'h0, lane_err}, {31'h0, exp_lane});
    repeat (15) @(negedge clk);
    chk("lane sticky", {31'h0, lane_err}, {31'h0, exp_lane});
    rst = 1'b1;
    #1;
    chk("lane cleared by rst", {31'h0, lane_err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
